acc_alu_core: RTL and testbench
===============================

# acc_alu_core

Parametrised accumulator ALU, successor to the 7-bit accumulator design. A WIDTH-bit accumulator takes an immediate operand and a 3-bit opcode. It provides load, add/subtract with carry, bitwise logic, and an optional multi-cycle shift-add multiply. It sits behind the tile top: operand from the dedicated input switches, opcode from bidirectional pins, accumulator and flags driven to the display outputs.

## Interface
Parameters:
- WIDTH, 7, accumulator/operand width in bits (legal 2..16)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- operand  input  WIDTH  immediate data
- opcode  input  3  operation select
- op_valid  input  1  opcode/operand qualifier; accepted when op_valid && !busy
- accu  output  WIDTH  accumulator register
- carry  output  1  carry/borrow flag register
- ovf  output  1  signed overflow flag register
- zero  output  1  combinational, accu == 0
- neg  output  1  combinational, accu[WIDTH-1]
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse when any op retires

## Operation
- Opcodes (acc_alu_pkg): 000 NOP, 001 LOAD, 010 ADC, 011 SBB, 100 AND, 101 OR, 110 XOR, 111 MUL.
- LOAD: accu <= operand; carry, ovf unchanged.
- ADC: {carry,accu} <= accu + operand + carry, computed WIDTH+1 wide; ovf <= signed overflow (both inputs same sign, result sign differs).
- SBB: {b,accu} <= accu - operand - carry, WIDTH+1 wide; carry <= b (1 = borrow); ovf <= signed overflow (input signs differ, result sign differs from accu).
- AND/OR/XOR: accu <= accu op operand; carry unchanged; ovf <= 0.
- NOP: no state change; done still pulses.
- MUL: 2*WIDTH product of unsigned accu × operand. accu <= product[WIDTH-1:0]; carry <= |product[2*WIDTH-1:WIDTH]; ovf <= 0.
- FSM: IDLE, MUL. IDLE + accepted MUL -> MUL. The multiplicand/multiplier are latched, the partial product cleared, and cnt set to WIDTH-1. MUL: one multiplier bit per cycle, cnt decrements. MUL with cnt==0 -> IDLE, results written.
- op_valid while busy: ignored, not queued; operand/opcode changes have no effect on the running multiply.
- op_valid low: nothing happens, done stays 0.

## Timing
- Reset values: accu 0, carry 0, ovf 0, busy 0, done 0. Hence zero 1, neg 0. FSM IDLE, cnt 0.
- Reset has priority over everything. Reset during MUL aborts it with no accu update and busy 0 next cycle.
- Single-cycle ops: accepted at edge E. Results visible after E, done high for the cycle after E.
- MUL accepted at edge E0: busy high from after E0 through edge E0+WIDTH. accu/carry update and done pulse after edge E0+WIDTH; busy low in the same cycle. Latency WIDTH+1 cycles issue-to-result. Back-to-back issue is possible on the cycle done is high.
- zero/neg follow accu combinationally, no extra latency.

## Configuration
- ACC_ALU_MUL_EN defined: MUL as above, MUL FSM and acc_alu_mul present.
- Undefined: opcode 111 behaves as NOP (done pulses, no state change). busy tied 0, no multiplier logic.

## Structure
- acc_alu_pkg: opcode localparams (OP_NOP..OP_MUL), FSM state enum (ST_IDLE, ST_MUL).
- Sub-module acc_alu_mul: shift-add sequencer (latched operands, partial-product register, cnt, start/done). Instantiated only under ACC_ALU_MUL_EN.
- Top holds accu/carry/ovf registers, single-cycle datapath, issue logic.

## Test plan (WIDTH=7)
- Reset, then LOAD 0x7F, ADC 0x01 -> accu 0x00, carry 1, zero 1, ovf 0; next ADC 0x00 -> accu 0x01, carry 0.
- LOAD 0x3F, ADC 0x01 (carry 0) -> accu 0x40, neg 1, ovf 1; SBB 0x41 -> accu 0x7F, carry 1 (borrow), ovf 0.
- LOAD 0x5A, AND 0x0F -> 0x0A; OR 0x70 -> 0x7A; XOR 0x7A -> 0x00, zero 1, carry unchanged, ovf 0.
- MUL enabled: LOAD 0x0C, MUL 0x0B -> busy for 7 cycles, then accu 0x04, carry 1 (0x84), done one cycle, total latency 8. LOAD 0x05 issued during busy is ignored.
- Reset asserted on 3rd busy cycle of MUL 0x03 -> all outputs at reset values next cycle; no late result or done.
- Macro undefined: MUL 0x03 with accu 0x05 -> accu stays 0x05, busy never asserts, done pulses once.

Source files
------------

// File: rtl/acc_alu_pkg.sv
// acc_alu_pkg: opcode encodings and multiply sequencer states shared by acc_alu_core and acc_alu_mul.
package acc_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADC  = 3'b010;
  localparam logic [2:0] OP_SBB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_st_t;

endpackage

// File: rtl/acc_alu_mul.sv
// acc_alu_mul: unsigned shift-add multiplier, one multiplier bit per cycle, WIDTH cycles busy after start.
// o_last/o_prod present the finished product combinationally on the final busy cycle; i_start is ignored while busy.
module acc_alu_mul
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic               o_busy,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_st_t            r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_pp;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_pp_nxt;

  // Add into the upper half, then shift the whole partial product right one bit.
  assign w_sum    = {1'b0, r_pp[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_pp_nxt = {w_sum, r_pp[WIDTH-1:1]};

  assign o_busy = (r_state == ST_MUL);
  assign o_last = (r_state == ST_MUL) && (r_cnt == '0);
  assign o_prod = w_pp_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_pp     <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_pp     <= '0;
            r_cnt    <= CW'(WIDTH - 1);
            r_state  <= ST_MUL;
          end
        end
        default: begin
          r_pp     <= w_pp_nxt;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/acc_alu_core.sv
// acc_alu_core: WIDTH-bit accumulator ALU; single-cycle ops retire one edge after issue, MUL (ACC_ALU_MUL_EN) after WIDTH+1 cycles.
// Ops presented while busy are dropped rather than queued; without ACC_ALU_MUL_EN opcode MUL retires as a NOP.
module acc_alu_core
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operand,
  input  logic [2:0]       opcode,
  input  logic             op_valid,
  output logic [WIDTH-1:0] accu,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0]   r_accu;
  logic               r_carry;
  logic               r_ovf;
  logic               r_done;

  logic               w_accept;
  logic               w_busy;
  logic               w_mul_start;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;

  assign w_accept = op_valid && !w_busy;
  assign w_add    = {1'b0, r_accu} + {1'b0, operand} + {{WIDTH{1'b0}}, r_carry};
  assign w_sub    = {1'b0, r_accu} - {1'b0, operand} - {{WIDTH{1'b0}}, r_carry};

`ifdef ACC_ALU_MUL_EN
  assign w_mul_start = w_accept && (opcode == OP_MUL);

  acc_alu_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_mul_start),
    .i_mcand  (r_accu),
    .i_mplier (operand),
    .o_busy   (w_busy),
    .o_last   (w_mul_last),
    .o_prod   (w_mul_prod)
  );
`else
  assign w_mul_start = 1'b0;
  assign w_busy      = 1'b0;
  assign w_mul_last  = 1'b0;
  assign w_mul_prod  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_accu  <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_mul_last) begin
        r_accu  <= w_mul_prod[WIDTH-1:0];
        r_carry <= |w_mul_prod[2*WIDTH-1:WIDTH];
        r_ovf   <= 1'b0;
        r_done  <= 1'b1;
      end else if (w_accept) begin
        // A starting multiply retires later, from the sequencer.
        r_done <= !w_mul_start;
        case (opcode)
          OP_LOAD: r_accu <= operand;
          OP_ADC: begin
            r_accu  <= w_add[WIDTH-1:0];
            r_carry <= w_add[WIDTH];
            r_ovf   <= (r_accu[WIDTH-1] == operand[WIDTH-1]) && (w_add[WIDTH-1] != r_accu[WIDTH-1]);
          end
          OP_SBB: begin
            r_accu  <= w_sub[WIDTH-1:0];
            r_carry <= w_sub[WIDTH];
            r_ovf   <= (r_accu[WIDTH-1] != operand[WIDTH-1]) && (w_sub[WIDTH-1] != r_accu[WIDTH-1]);
          end
          OP_AND: begin
            r_accu <= r_accu & operand;
            r_ovf  <= 1'b0;
          end
          OP_OR: begin
            r_accu <= r_accu | operand;
            r_ovf  <= 1'b0;
          end
          OP_XOR: begin
            r_accu <= r_accu ^ operand;
            r_ovf  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign accu  = r_accu;
  assign carry = r_carry;
  assign ovf   = r_ovf;
  assign done  = r_done;
  assign busy  = w_busy;
  assign zero  = (r_accu == '0);
  assign neg   = r_accu[WIDTH-1];

endmodule

// File: tb/tb_acc_alu_core.sv
// tb_acc_alu_core: directed vectors for acc_alu_core at WIDTH=7, checked against an arithmetic model every cycle.
// Follows ACC_ALU_MUL_EN to decide whether opcode MUL multiplies or retires as a NOP.
module tb_acc_alu_core;
  import acc_alu_pkg::*;

  localparam int W    = 7;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);
`ifdef ACC_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] operand = '0;
  logic [2:0]   opcode = OP_NOP;
  logic         op_valid = 1'b0;
  logic [W-1:0] accu;
  logic         carry, ovf, zero, neg, busy, done;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  acc_alu_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .operand(operand), .opcode(opcode), .op_valid(op_valid),
    .accu(accu), .carry(carry), .ovf(ovf), .zero(zero), .neg(neg), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]   accu;
    logic           carry;
    logic           ovf;
    logic           done;
    logic [4:0]     left;
    logic [2*W-1:0] prod;
  } mst_t;

  mst_t m;

  function automatic int sgn(input int v);
    return (v >= HALF) ? v - (1 << W) : v;
  endfunction

  function automatic bit out_of_range(input int v);
    return (v > HALF - 1) || (v < -HALF);
  endfunction

  // Next architectural state from the operation definitions, in plain integer arithmetic.
  function automatic mst_t step(input mst_t s, input logic rst, input logic vld,
                                input logic [2:0] op, input logic [W-1:0] d);
    mst_t n;
    int a, b, c, r;
    n = s;
    n.done = 1'b0;
    if (!rst) begin
      n = '0;
      return n;
    end
    a = int'(s.accu);
    b = int'(d);
    c = int'(s.carry);
    if (s.left != 0) begin
      n.left = s.left - 5'd1;
      if (s.left == 5'd1) begin
        r       = int'(s.prod);
        n.accu  = W'(r & MASK);
        n.carry = (r >> W) != 0;
        n.ovf   = 1'b0;
        n.done  = 1'b1;
      end
      return n;
    end
    if (!vld) return n;
    n.done = 1'b1;
    case (op)
      OP_LOAD: n.accu = d;
      OP_ADC: begin
        r       = a + b + c;
        n.accu  = W'(r & MASK);
        n.carry = r > MASK;
        n.ovf   = out_of_range(sgn(a) + sgn(b) + c);
      end
      OP_SBB: begin
        r       = a - b - c;
        n.accu  = W'(r & MASK);
        n.carry = r < 0;
        n.ovf   = out_of_range(sgn(a) - sgn(b) - c);
      end
      OP_AND: begin n.accu = W'(a & b); n.ovf = 1'b0; end
      OP_OR:  begin n.accu = W'(a | b); n.ovf = 1'b0; end
      OP_XOR: begin n.accu = W'(a ^ b); n.ovf = 1'b0; end
      OP_MUL: begin
        if (MUL_EN) begin
          n.left = 5'(W);
          n.prod = (2*W)'(a * b);
          n.done = 1'b0;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst_n, op_valid, opcode, operand);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_accu",  32'(accu),  32'(m.accu));
      chk("cyc_carry", 32'(carry), 32'(m.carry));
      chk("cyc_ovf",   32'(ovf),   32'(m.ovf));
      chk("cyc_zero",  32'(zero),  32'(m.accu == '0));
      chk("cyc_neg",   32'(neg),   32'(m.accu[W-1]));
      chk("cyc_busy",  32'(busy),  32'(m.left != 0));
      chk("cyc_done",  32'(done),  32'(m.done));
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] d);
    opcode   = op;
    operand  = d;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    operand  = 7'h2A;
    opcode   = OP_AND;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_accu", 32'(accu), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();

    issue(OP_LOAD, 7'h7F);
    issue(OP_ADC, 7'h01);
    chk("adc_wrap_accu",  32'(accu),  0);
    chk("adc_wrap_carry", 32'(carry), 1);
    chk("adc_wrap_zero",  32'(zero),  1);
    chk("adc_wrap_ovf",   32'(ovf),   0);
    chk("adc_wrap_done",  32'(done),  1);
    issue(OP_ADC, 7'h00);
    chk("adc_cin_accu",  32'(accu),  1);
    chk("adc_cin_carry", 32'(carry), 0);
    tick();
    chk("idle_done", 32'(done), 0);

    issue(OP_LOAD, 7'h3F);
    issue(OP_ADC, 7'h01);
    chk("adc_ovf_accu", 32'(accu), 32'h40);
    chk("adc_ovf_neg",  32'(neg),  1);
    chk("adc_ovf_ovf",  32'(ovf),  1);
    issue(OP_SBB, 7'h41);
    chk("sbb_accu",  32'(accu),  32'h7F);
    chk("sbb_carry", 32'(carry), 1);
    chk("sbb_ovf",   32'(ovf),   0);

    issue(OP_LOAD, 7'h5A);
    issue(OP_AND, 7'h0F);
    chk("and_accu", 32'(accu), 32'h0A);
    issue(OP_OR, 7'h70);
    chk("or_accu", 32'(accu), 32'h7A);
    issue(OP_XOR, 7'h7A);
    chk("xor_accu",  32'(accu),  0);
    chk("xor_zero",  32'(zero),  1);
    chk("xor_carry", 32'(carry), 1);
    chk("xor_ovf",   32'(ovf),   0);
    issue(OP_NOP, 7'h11);
    chk("nop_accu", 32'(accu), 0);
    chk("nop_done", 32'(done), 1);

    if (MUL_EN) begin
      int cnt;
      int seen;
      issue(OP_LOAD, 7'h0C);
      issue(OP_MUL, 7'h0B);
      chk("mul_busy", 32'(busy), 1);
      chk("mul_done_early", 32'(done), 0);
      tick();
      tick();
      issue(OP_LOAD, 7'h05);
      cnt = 3;
      while (!done && cnt < 20) begin
        tick();
        cnt++;
      end
      chk("mul_latency", 32'(cnt + 1), 8);
      chk("mul_accu",  32'(accu),  32'h04);
      chk("mul_carry", 32'(carry), 1);
      chk("mul_busy_end", 32'(busy), 0);
      tick();
      chk("mul_done_pulse", 32'(done), 0);

      issue(OP_LOAD, 7'h05);
      issue(OP_MUL, 7'h03);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("mulrst_accu",  32'(accu),  0);
      chk("mulrst_carry", 32'(carry), 0);
      chk("mulrst_busy",  32'(busy),  0);
      chk("mulrst_done",  32'(done),  0);
      chk("mulrst_zero",  32'(zero),  1);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done) seen++;
      end
      chk("mulrst_no_late_done", 32'(seen), 0);
      chk("mulrst_accu_late", 32'(accu), 0);
    end else begin
      issue(OP_LOAD, 7'h05);
      issue(OP_MUL, 7'h03);
      chk("nomul_accu", 32'(accu), 32'h05);
      chk("nomul_busy", 32'(busy), 0);
      chk("nomul_done", 32'(done), 1);
      tick();
      chk("nomul_done_once", 32'(done), 0);
      chk("nomul_busy_after", 32'(busy), 0);
    end

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
